// File: rtl/ttt_pkg.sv
// Tic-tac-toe shared definitions: cell codes, FSM states,
// win-line table and the line-completion check.
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_P1    = 2'd1;
  localparam logic [1:0] CELL_P2    = 2'd2;
  localparam logic [1:0] CELL_DRAW  = 2'd3;

  localparam logic [1:0] ST_PLAY  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int N_CELLS = 9;
  localparam int N_LINES = 8;

  // Cell index triples: 3 rows, 3 columns, 2 diagonals.
  localparam logic [3:0] WIN_LINE [N_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // True when player p owns all three cells of any line.
  function automatic logic line_win(
    input logic [17:0] b,
    input logic [1:0]  p
  );
    logic hit;
    logic all;
    hit = 1'b0;
    for (int l = 0; l < N_LINES; l++) begin
      all = 1'b1;
      for (int j = 0; j < 3; j++) begin
        if (b[2*int'(WIN_LINE[l][j]) +: 2] != p) begin
          all = 1'b0;
        end
      end
      hit = hit | all;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ttt_key_debounce.sv
// One push-button input path: 2-flop synchronizer,
// stability counter, rising-edge pulse of the clean level.
module ttt_key_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic pulse_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          prev_q;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], key_i};
    end
  end

  // Accept a new level only after it has held long enough;
  // any reversal before that restarts the count.
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state and previous clean level for edge detect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      prev_q <= lvl_q;
    end
  end

  assign pulse_o = lvl_q & ~prev_q;

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe controller: debounced buttons, move validation,
// turn order, win/draw detection, registered board for display.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter int         DEBOUNCE_CYC = 500000,
  parameter logic [1:0] FIRST_PLAYER = 2'd1
) (
  input  logic        freq,
  input  logic        rst,
  input  logic [8:0]  key,
  input  logic        key_clr,
  output logic [17:0] board,
  output logic [1:0]  turn,
  output logic [1:0]  winner,
  output logic        game_over,
  output logic [3:0]  move_cnt
);

  logic [8:0]  key_pls;
  logic        clr_pls;
  logic [8:0]  occ;
  logic        mv_ok;

  logic [1:0]  state_q, state_d;
  logic [17:0] board_q, board_d;
  logic [1:0]  turn_q, turn_d;
  logic [1:0]  winner_q, winner_d;
  logic        over_q, over_d;
  logic [3:0]  cnt_q, cnt_d;

  for (genvar k = 0; k < N_CELLS; k++) begin : g_key
    ttt_key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .clk_i  (freq),
      .rst_i  (rst),
      .key_i  (key[k]),
      .pulse_o(key_pls[k])
    );
    assign occ[k] = |board_q[2*k +: 2];
  end

  ttt_key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_db_clr (
    .clk_i  (freq),
    .rst_i  (rst),
    .key_i  (key_clr),
    .pulse_o(clr_pls)
  );

  assign mv_ok = $onehot(key_pls) && ((key_pls & occ) == 9'd0);

  // Next-state: new game beats everything, then the FSM.
  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    turn_d   = turn_q;
    winner_d = winner_q;
    over_d   = over_q;
    cnt_d    = cnt_q;
    if (clr_pls) begin
      state_d  = ST_PLAY;
      board_d  = '0;
      turn_d   = FIRST_PLAYER;
      winner_d = CELL_EMPTY;
      over_d   = 1'b0;
      cnt_d    = 4'd0;
    end else begin
      unique case (state_q)
        ST_PLAY: begin
          if (mv_ok) begin
            for (int k = 0; k < N_CELLS; k++) begin
              if (key_pls[k]) begin
                board_d[2*k +: 2] = turn_q;
              end
            end
            cnt_d   = cnt_q + 4'd1;
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (line_win(board_q, turn_q)) begin
            winner_d = turn_q;
            over_d   = 1'b1;
            state_d  = ST_DONE;
          end else if (cnt_q == 4'd9) begin
            winner_d = CELL_DRAW;
            over_d   = 1'b1;
            state_d  = ST_DONE;
          end else begin
            turn_d  = (turn_q == CELL_P1) ? CELL_P2 : CELL_P1;
            state_d = ST_PLAY;
          end
        end
        ST_DONE: begin
        end
        default: begin
          state_d = ST_PLAY;
        end
      endcase
    end
  end

  // Game state registers; all outputs come straight from here.
  always_ff @(posedge freq or posedge rst) begin
    if (rst) begin
      state_q  <= ST_PLAY;
      board_q  <= '0;
      turn_q   <= FIRST_PLAYER;
      winner_q <= CELL_EMPTY;
      over_q   <= 1'b0;
      cnt_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      turn_q   <= turn_d;
      winner_q <= winner_d;
      over_q   <= over_d;
      cnt_q    <= cnt_d;
    end
  end

  assign board     = board_q;
  assign turn      = turn_q;
  assign winner    = winner_q;
  assign game_over = over_q;
  assign move_cnt  = cnt_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl against a
// rules-level game model; directed cases plus random play.
module tb_ttt_game_ctrl;

  logic        freq;
  logic        rst;
  logic [8:0]  key;
  logic        key_clr;
  logic [17:0] board;
  logic [1:0]  turn;
  logic [1:0]  winner;
  logic        game_over;
  logic [3:0]  move_cnt;

  int nvec = 0;
  int nerr = 0;

  int mb [9];
  int mturn;
  int mwin;
  int mcnt;
  bit mover;

  ttt_game_ctrl #(
    .DEBOUNCE_CYC(4),
    .FIRST_PLAYER(2'd1)
  ) dut (
    .freq     (freq),
    .rst      (rst),
    .key      (key),
    .key_clr  (key_clr),
    .board    (board),
    .turn     (turn),
    .winner   (winner),
    .game_over(game_over),
    .move_cnt (move_cnt)
  );

  initial freq = 1'b0;
  always #5 freq = ~freq;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 9; i++) mb[i] = 0;
    mturn = 1;
    mwin  = 0;
    mcnt  = 0;
    mover = 0;
  endfunction

  function automatic bit m_owns(int p);
    bit w;
    w = 0;
    for (int r = 0; r < 3; r++) begin
      if (mb[3*r] == p && mb[3*r+1] == p && mb[3*r+2] == p) w = 1;
      if (mb[r] == p && mb[r+3] == p && mb[r+6] == p) w = 1;
    end
    if (mb[0] == p && mb[4] == p && mb[8] == p) w = 1;
    if (mb[2] == p && mb[4] == p && mb[6] == p) w = 1;
    return w;
  endfunction

  function automatic void m_apply(logic [8:0] mask);
    int idx;
    if (mover) return;
    if ($countones(mask) != 1) return;
    idx = 0;
    for (int i = 0; i < 9; i++) if (mask[i]) idx = i;
    if (mb[idx] != 0) return;
    mb[idx] = mturn;
    mcnt++;
    if (m_owns(mturn)) begin
      mwin  = mturn;
      mover = 1;
    end else if (mcnt == 9) begin
      mwin  = 3;
      mover = 1;
    end else begin
      mturn = 3 - mturn;
    end
  endfunction

  function automatic logic [17:0] m_board();
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) b = b | (18'(mb[i]) << (2*i));
    return b;
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ".board"}, 32'(board), 32'(m_board()));
    chk({tag, ".turn"}, 32'(turn), 32'(mturn));
    chk({tag, ".winner"}, 32'(winner), 32'(mwin));
    chk({tag, ".over"}, 32'(game_over), 32'(mover));
    chk({tag, ".cnt"}, 32'(move_cnt), 32'(mcnt));
  endtask

  // Hold a button combination, then release; timing checked on moves.
  task automatic do_press(input logic [8:0] mask, input logic clr);
    logic [17:0] ob;
    int ot, ow, n;
    bit moved;
    ob = m_board();
    ot = mturn;
    ow = mwin;
    if (clr) m_reset();
    else m_apply(mask);
    moved = !clr && (m_board() != ob);
    key = mask;
    key_clr = clr;
    if (moved) begin
      n = 0;
      while (board === ob && n < 40) begin
        @(posedge freq); #1;
        n++;
      end
      chk("move_seen", 32'(n < 40), 32'd1);
      chk("board_1cyc", 32'(board), 32'(m_board()));
      chk("winner_lag", 32'(winner), 32'(ow));
      chk("turn_lag", 32'(turn), 32'(ot));
      @(posedge freq); #1;
      chk("winner_2cyc", 32'(winner), 32'(mwin));
      chk("over_2cyc", 32'(game_over), 32'(mover));
      chk("turn_2cyc", 32'(turn), 32'(mturn));
    end else begin
      repeat (12) @(posedge freq);
    end
    key = '0;
    key_clr = 1'b0;
    repeat (12) @(posedge freq);
    #1;
  endtask

  task automatic async_reset();
    @(posedge freq); #3;
    rst = 1'b1;
    #1;
    m_reset();
    chk_all("async_rst");
    @(posedge freq); #1;
    rst = 1'b0;
  endtask

  initial begin
    int seq_win [5] = '{0, 3, 1, 4, 2};
    int seq_drw [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    logic [17:0] snap;
    rst = 1'b0;
    key = '0;
    key_clr = 1'b0;
    m_reset();
    #2 rst = 1'b1;
    #1;
    chk_all("reset");
    @(posedge freq); #1;
    rst = 1'b0;
    repeat (3) @(posedge freq);
    #1;

    do_press(9'h010, 1'b0);
    chk("k4_board", 32'(board), 32'h00100);
    chk_all("k4");
    do_press(9'h010, 1'b0);
    chk("k4_again_turn", 32'(turn), 32'd2);
    chk_all("k4_again");

    for (int i = 0; i < 10; i++) begin
      key = (i % 2 == 0) ? 9'h001 : 9'h000;
      repeat (2) @(posedge freq);
    end
    key = '0;
    repeat (12) @(posedge freq);
    #1;
    chk_all("bounce");
    do_press(9'h101, 1'b0);
    chk_all("multi");

    async_reset();

    do_press(9'h000, 1'b1);
    for (int i = 0; i < 5; i++) do_press(9'(1 << seq_win[i]), 1'b0);
    chk("win_board", 32'(board), 32'h00295);
    chk("win_who", 32'(winner), 32'd1);
    chk_all("win");
    snap = board;
    do_press(9'h100, 1'b0);
    chk("done_hold", 32'(board), 32'(snap));

    do_press(9'h020, 1'b1);
    chk("clr_board", 32'(board), 32'h0);
    chk_all("clr_k5");
    do_press(9'h020, 1'b0);
    chk("k5_board", 32'(board), 32'h00400);

    do_press(9'h000, 1'b1);
    for (int i = 0; i < 9; i++) do_press(9'(1 << seq_drw[i]), 1'b0);
    chk("draw_who", 32'(winner), 32'd3);
    chk("draw_cnt", 32'(move_cnt), 32'd9);
    chk_all("draw");

    for (int i = 0; i < 200; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (i == 120) async_reset();
      if (r < 6) do_press(9'h000, 1'b1);
      else if (r < 16) do_press(9'($urandom_range(1, 511)), 1'b0);
      else do_press(9'(1 << $urandom_range(0, 8)), 1'b0);
      chk_all("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
